m6809_uart_fifo: RTL and testbench
==================================

Name: m6809_uart_fifo

Overview:
- Memory-mapped, buffered UART for the 6809 bus card CPLD.
- Two-register CPU interface; parametrised TX and RX FIFOs; programmable bit period; hardware RTS/CTS flow control; open-drain-style interrupt request.
- Sits between the host bus decode (cs_b is generated externally, e.g. from the 0xAxxx decode) and the Pi UART header pins.
- Successor to the unbuffered single-byte UART: adds FIFO depth, flow-control threshold and interrupt enables.

Parameters:
- BAUD_DIV, 139: clk cycles per serial bit (16 MHz / 115200); legal range 8..65535.
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW entries per direction.
- RTS_THRESH, 12: RX occupancy at or above which rts_b deasserts (high); must be < 2**FIFO_AW.

Ports:
- clk  input  1  bus-synchronous clock (filtered E clock); all state on rising edge.
- reset_b  input  1  reset, asynchronous, active-low.
- cs_b  input  1  chip select, active-low.
- rnw  input  1  1 = read, 0 = write.
- regsel  input  1  0 = status/control, 1 = data.
- din  input  8  write data.
- dout  output  8  read data, registered.
- irq_b  output  1  interrupt request, active-low.
- rxd  input  1  serial in, asynchronous.
- txd  output  1  serial out, idle high.
- cts_b  input  1  remote ready to receive, active-low.
- rts_b  output  1  we are ready to receive, active-low.

Behaviour:
- Reset values: txd=1, irq_b=1, dout=0x00, rts_b=0, control=0x00, both FIFOs empty, TX and RX FSMs IDLE.
- Asynchronous assert; synchronous-safe release.
- Reset mid-frame aborts the frame; txd returns to 1 immediately.

Access and strobe:
- An access is the first clk edge with cs_b low after cs_b was high (edge-detected, one strobe per access).
- Later cycles of the same select have no side effects.

Register map:
- Read regsel=0 (status): bit0 RX not empty; bit1 TX not full; bit2 RX ≥ RTS_THRESH; bit3 TX idle (FIFO empty and FSM IDLE); bit7 irq pending; bits 6:4 = 0.
- Write regsel=0 (control): bit0 RX irq enable; bit1 TX irq enable; other bits ignored.
- Read regsel=1: dout = RX head; pop on strobe. RX empty returns 0x00 with no pop.
- Write regsel=1: push din to TX. TX full: write dropped silently.
- dout updates on the strobe edge and holds until the next read strobe.

Interrupt:
- irq_b = !((ctl0 & rx_not_empty) | (ctl1 & tx_not_full)), registered; 1-cycle latency from the condition.

FIFOs:
- Simultaneous push and pop on the same FIFO: both take effect, count unchanged. This holds when full (RX full + CPU pop + receiver push) and when empty (pop ignored, push succeeds).

TX FSM (IDLE → START → DATA → STOP → IDLE):
- Leaves IDLE when TX not empty and cts_b==0.
- txd start bit appears 2 cycles after the data-write strobe when idle.
- Each bit lasts BAUD_DIV cycles; data sent LSB first, 8N1.
- cts_b high mid-byte: current byte completes; no new byte starts.

RX FSM (IDLE → START → DATA → STOP → IDLE):
- rxd passes a 2-flop synchroniser.
- Falling edge enters START; re-sample at BAUD_DIV/2. If high, false start: return to IDLE.
- Data sampled at mid-bit.
- At stop-bit sample the byte is pushed; status bit0 sets 1 cycle later.
- RX full at push: byte discarded.
- Bad stop bit (0): byte still pushed.

Flow control:
- rts_b = (rx_count ≥ RTS_THRESH), registered.

Optional Feature:
- Macro: M6809_UART_ERROR_FLAGS_EN.
- With it defined:
  - status bit4 = sticky overrun (RX push while full).
  - status bit5 = sticky framing error (stop bit sampled 0); the bad byte is not pushed.
  - Both bits clear on a status read strobe.
- Without it: bits 5:4 read 0; overrun bytes are dropped and framing errors are ignored (byte pushed).

Decomposition:
- Package m6809_uart_pkg holds:
  - register offsets REG_STATUS=0, REG_DATA=1;
  - status and control bit index constants;
  - TX/RX FSM state encodings.
- Sub-module m6809_sync_fifo (params WIDTH=8, AW), instantiated for TX and RX.
  - Ports: push, pop, din, dout, full, empty, count.
  - Count is AW+1 bits wide.

Test Plan:
- Reset then read status -> 0x0A (TX not full, TX idle); txd=1, rts_b=0, irq_b=1.
- Write 0x55 to data, cts_b=0 -> txd low at strobe+2 cycles; bits 1,0,1,0,1,0,1,0 each BAUD_DIV cycles; stop high; status bit3 returns 1.
- Drive 0xA3 on rxd at BAUD_DIV rate, ctl=0x01 -> irq_b low; data read = 0xA3; irq_b high 1 cycle after pop.
- Send 12 bytes with no CPU reads -> rts_b high after the 12th; one read -> rts_b low.
- Send 2**FIFO_AW+1 bytes -> first 16 read back in order; 17th lost; with EN, status bit4=1, and 0 after a status read.
- Hold cts_b=1 and write 3 bytes -> txd stays 1; release cts_b -> 3 frames back-to-back with no idle gap.

Source files
------------

// File: rtl/m6809_uart_pkg.sv
// +--------------------------------------------------------------------------+
// | m6809_uart_pkg : register map, status/control bits, FSM encodings         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package m6809_uart_pkg;

  localparam logic REG_STATUS = 1'b0;
  localparam logic REG_DATA   = 1'b1;

  localparam int ST_RX_NE    = 0;
  localparam int ST_TX_NF    = 1;
  localparam int ST_RX_THR   = 2;
  localparam int ST_TX_IDLE  = 3;
  localparam int ST_OVERRUN  = 4;
  localparam int ST_FRAMING  = 5;
  localparam int ST_IRQ      = 7;

  localparam int CTL_RX_IE   = 0;
  localparam int CTL_TX_IE   = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/m6809_sync_fifo.sv
// +--------------------------------------------------------------------------+
// | m6809_sync_fifo : first-word-fall-through FIFO, 2**AW entries            |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module m6809_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] C_DEPTH = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rptr];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/m6809_uart_fifo.sv
// +--------------------------------------------------------------------------+
// | m6809_uart_fifo : buffered 6809 bus UART with RTS/CTS and IRQ            |
// | Option: M6809_UART_ERROR_FLAGS_EN adds sticky overrun/framing flags.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module m6809_uart_fifo
  import m6809_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 139,
  parameter int FIFO_AW    = 4,
  parameter int RTS_THRESH = 12
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       cs_b,
  input  logic       rnw,
  input  logic       regsel,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq_b,
  input  logic       rxd,
  output logic       txd,
  input  logic       cts_b,
  output logic       rts_b
);

  localparam logic [15:0]      C_BIT_LAST   = 16'(BAUD_DIV - 1);
  localparam logic [15:0]      C_HALF_LAST  = 16'(BAUD_DIV / 2 - 1);
  localparam logic [FIFO_AW:0] C_RTS_THRESH = (FIFO_AW + 1)'(RTS_THRESH);

  // Reset asserts asynchronously and releases two clocks later.
  logic [1:0] r_rst_sync;
  logic       w_rst_b;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_b = r_rst_sync[1];

  logic       r_cs_b_d;
  logic [1:0] r_cts_sync;
  logic [1:0] r_rx_sync;
  logic       r_rx_prev;

  always_ff @(posedge clk or negedge w_rst_b) begin
    if (!w_rst_b) begin
      r_cs_b_d   <= 1'b1;
      r_cts_sync <= 2'b11;
      r_rx_sync  <= 2'b11;
      r_rx_prev  <= 1'b1;
    end else begin
      r_cs_b_d   <= cs_b;
      r_cts_sync <= {r_cts_sync[0], cts_b};
      r_rx_sync  <= {r_rx_sync[0], rxd};
      r_rx_prev  <= r_rx_sync[1];
    end
  end

  logic w_strobe, w_rd_stat, w_rd_data, w_wr_ctl, w_wr_data;
  assign w_strobe  = !cs_b && r_cs_b_d;
  assign w_rd_stat = w_strobe &&  rnw && (regsel == REG_STATUS);
  assign w_rd_data = w_strobe &&  rnw && (regsel == REG_DATA);
  assign w_wr_ctl  = w_strobe && !rnw && (regsel == REG_STATUS);
  assign w_wr_data = w_strobe && !rnw && (regsel == REG_DATA);

  logic [7:0]       w_tx_head, w_rx_head;
  logic             w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [FIFO_AW:0] w_tx_count, w_rx_count;
  logic             w_tx_pop, w_rx_push;

  m6809_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .reset_b (w_rst_b),
    .push    (w_wr_data),
    .pop     (w_tx_pop),
    .din     (din),
    .dout    (w_tx_head),
    .full    (w_tx_full),
    .empty   (w_tx_empty),
    .count   (w_tx_count)
  );

  logic [7:0] r_rx_shift;

  m6809_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .reset_b (w_rst_b),
    .push    (w_rx_push),
    .pop     (w_rd_data),
    .din     (r_rx_shift),
    .dout    (w_rx_head),
    .full    (w_rx_full),
    .empty   (w_rx_empty),
    .count   (w_rx_count)
  );

  // ---------------- transmitter ----------------
  tx_state_t  r_tx_state, w_tx_next;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_txd;
  logic        w_tx_bit_done, w_tx_can_go, w_txd_next;

  assign w_tx_bit_done = (r_tx_cnt == C_BIT_LAST);
  assign w_tx_can_go   = !w_tx_empty && !r_cts_sync[1];

  always_ff @(posedge clk or negedge w_rst_b) begin
    if (!w_rst_b) r_tx_state <= TX_IDLE;
    else          r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next  = r_tx_state;
    w_tx_pop   = 1'b0;
    w_txd_next = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_tx_can_go) begin
          w_tx_next = TX_START;
          w_tx_pop  = 1'b1;
        end
      end
      TX_START: begin
        w_txd_next = 1'b0;
        if (w_tx_bit_done) w_tx_next = TX_DATA;
      end
      TX_DATA: begin
        w_txd_next = r_tx_shift[0];
        if (w_tx_bit_done && (r_tx_bit == 3'd7)) w_tx_next = TX_STOP;
      end
      TX_STOP: begin
        // Chain straight into the next start bit so queued bytes leave back-to-back.
        if (w_tx_bit_done) begin
          if (w_tx_can_go) begin
            w_tx_next = TX_START;
            w_tx_pop  = 1'b1;
          end else begin
            w_tx_next = TX_IDLE;
          end
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_b) begin
    if (!w_rst_b) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_txd <= w_txd_next;
      if (r_tx_state == TX_IDLE || w_tx_bit_done) r_tx_cnt <= '0;
      else                                        r_tx_cnt <= r_tx_cnt + 1'b1;
      if (w_tx_pop)
        r_tx_shift <= w_tx_head;
      else if (r_tx_state == TX_DATA && w_tx_bit_done)
        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
      if (r_tx_state == TX_START)
        r_tx_bit <= '0;
      else if (r_tx_state == TX_DATA && w_tx_bit_done)
        r_tx_bit <= r_tx_bit + 1'b1;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t   r_rx_state, w_rx_next;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic        w_rx_in, w_rx_fall, w_rx_half, w_rx_bit_done, w_rx_stop_sample;

  assign w_rx_in       = r_rx_sync[1];
  assign w_rx_fall     = r_rx_prev && !w_rx_in;
  assign w_rx_half     = (r_rx_cnt == C_HALF_LAST);
  assign w_rx_bit_done = (r_rx_cnt == C_BIT_LAST);

  always_ff @(posedge clk or negedge w_rst_b) begin
    if (!w_rst_b) r_rx_state <= RX_IDLE;
    else          r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next        = r_rx_state;
    w_rx_stop_sample = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      RX_START: if (w_rx_half) w_rx_next = w_rx_in ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_bit_done && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP: begin
        if (w_rx_bit_done) begin
          w_rx_stop_sample = 1'b1;
          w_rx_next        = RX_IDLE;
        end
      end
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // After the half-bit check the counter restarts, so later samples land mid-bit.
  always_ff @(posedge clk or negedge w_rst_b) begin
    if (!w_rst_b) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      if (r_rx_state == RX_IDLE || (r_rx_state == RX_START && w_rx_half) || w_rx_bit_done)
        r_rx_cnt <= '0;
      else
        r_rx_cnt <= r_rx_cnt + 1'b1;
      if (r_rx_state == RX_START)
        r_rx_bit <= '0;
      else if (r_rx_state == RX_DATA && w_rx_bit_done)
        r_rx_bit <= r_rx_bit + 1'b1;
      if (r_rx_state == RX_DATA && w_rx_bit_done)
        r_rx_shift <= {w_rx_in, r_rx_shift[7:1]};
    end
  end

  logic w_err_overrun, w_err_framing;

`ifdef M6809_UART_ERROR_FLAGS_EN
  logic r_overrun, r_framing;

  assign w_rx_push = w_rx_stop_sample && w_rx_in;

  always_ff @(posedge clk or negedge w_rst_b) begin
    if (!w_rst_b) begin
      r_overrun <= 1'b0;
      r_framing <= 1'b0;
    end else begin
      if (w_rd_stat) begin
        r_overrun <= 1'b0;
        r_framing <= 1'b0;
      end
      if (w_rx_push && w_rx_full && !w_rd_data) r_overrun <= 1'b1;
      if (w_rx_stop_sample && !w_rx_in)         r_framing <= 1'b1;
    end
  end

  assign w_err_overrun = r_overrun;
  assign w_err_framing = r_framing;
`else
  assign w_rx_push     = w_rx_stop_sample;
  assign w_err_overrun = 1'b0;
  assign w_err_framing = 1'b0;
`endif

  // ---------------- CPU registers ----------------
  logic [1:0] r_ctl;
  logic [7:0] r_dout;
  logic       r_irq_b, r_rts_b;
  logic       w_irq_cond;
  logic [7:0] w_status;

  assign w_irq_cond = (r_ctl[CTL_RX_IE] && !w_rx_empty) || (r_ctl[CTL_TX_IE] && !w_tx_full);

  always_comb begin
    w_status             = '0;
    w_status[ST_RX_NE]   = !w_rx_empty;
    w_status[ST_TX_NF]   = !w_tx_full;
    w_status[ST_RX_THR]  = (w_rx_count >= C_RTS_THRESH);
    w_status[ST_TX_IDLE] = (w_tx_count == '0) && (r_tx_state == TX_IDLE);
    w_status[ST_OVERRUN] = w_err_overrun;
    w_status[ST_FRAMING] = w_err_framing;
    w_status[ST_IRQ]     = w_irq_cond;
  end

  always_ff @(posedge clk or negedge w_rst_b) begin
    if (!w_rst_b) begin
      r_ctl   <= '0;
      r_dout  <= '0;
      r_irq_b <= 1'b1;
      r_rts_b <= 1'b0;
    end else begin
      r_irq_b <= !w_irq_cond;
      r_rts_b <= (w_rx_count >= C_RTS_THRESH);
      if (w_wr_ctl) r_ctl <= din[1:0];
      if (w_rd_stat)
        r_dout <= w_status;
      else if (w_rd_data)
        r_dout <= w_rx_empty ? 8'h00 : w_rx_head;
    end
  end

  assign dout  = r_dout;
  assign irq_b = r_irq_b;
  assign rts_b = r_rts_b;
  assign txd   = r_txd;

endmodule

`default_nettype wire

// File: tb/tb_m6809_uart_fifo.sv
// +--------------------------------------------------------------------------+
// | tb_m6809_uart_fifo : scoreboard bench for the buffered 6809 UART          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_m6809_uart_fifo;

  localparam int BAUD  = 16;
  localparam int FRAME = 10 * BAUD;
`ifdef M6809_UART_ERROR_FLAGS_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       cs_b = 1'b1;
  logic       rnw = 1'b1;
  logic       regsel = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       irq_b;
  logic       rxd = 1'b1;
  logic       txd;
  logic       cts_b = 1'b0;
  logic       rts_b;

  m6809_uart_fifo #(.BAUD_DIV(BAUD), .FIFO_AW(4), .RTS_THRESH(12)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .cs_b    (cs_b),
    .rnw     (rnw),
    .regsel  (regsel),
    .din     (din),
    .dout    (dout),
    .irq_b   (irq_b),
    .rxd     (rxd),
    .txd     (txd),
    .cts_b   (cts_b),
    .rts_b   (rts_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] val;
    string      name;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] tx_q[$];
  int         tx_starts[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Read-data monitor: compares dout half a cycle after each read strobe.
  logic cs_prev = 1'b1;
  logic rd_seen = 1'b0;
  always @(posedge clk) begin
    rd_seen <= !cs_b && cs_prev && rnw;
    cs_prev <= cs_b;
  end

  always @(negedge clk) begin
    rd_exp_t e;
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_unexpected: got 0x%0h expected no read", dout);
      end else begin
        e = rd_q.pop_front();
        check(e.name, dout, e.val);
      end
    end
  end

  // Serial monitor: decodes every txd frame and checks it against tx_q.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset_b && txd === 1'b0) begin
        tx_starts.push_back(cyc);
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = txd;
        end
        repeat (BAUD) @(negedge clk);
        check("tx_stop_bit", txd, 1);
        if (tx_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_unexpected: got 0x%0h expected no frame", b);
        end else begin
          check("tx_byte", b, tx_q.pop_front());
        end
      end
    end
  end

  task automatic cpu_write(input logic rs, input logic [7:0] d);
    @(posedge clk); #1;
    cs_b = 1'b0; rnw = 1'b0; regsel = rs; din = d;
    @(posedge clk); #1;
    cs_b = 1'b1; rnw = 1'b1;
  endtask

  task automatic cpu_read(input logic rs, input logic [7:0] exp, input string name);
    rd_q.push_back('{exp, name});
    @(posedge clk); #1;
    cs_b = 1'b0; rnw = 1'b1; regsel = rs;
    @(posedge clk); #1;
    cs_b = 1'b1;
  endtask

  task automatic rx_bit(input logic v);
    rxd = v;
    repeat (BAUD) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop);
    rx_bit(1'b1);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;

    // Reset state
    wait_cyc(3);
    check("rst_txd", txd, 1);
    check("rst_rts_b", rts_b, 0);
    check("rst_irq_b", irq_b, 1);
    check("rst_dout", dout, 8'h00);
    reset_b = 1'b1;
    wait_cyc(5);
    cpu_read(0, 8'h0A, "status_after_reset");

    // Single TX byte: start bit two clocks after the strobe
    tx_q.push_back(8'h55);
    cpu_write(1, 8'h55);
    wait_cyc(1);
    check("tx_start_strobe+1", txd, 1);
    wait_cyc(1);
    check("tx_start_strobe+2", txd, 0);
    cpu_read(0, 8'h02, "status_tx_busy");
    wait_cyc(FRAME + 10);
    cpu_read(0, 8'h0A, "status_tx_done");

    // cts_b raised mid-byte: current byte finishes, next waits
    tx_starts.delete();
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    cpu_write(1, 8'h11);
    cpu_write(1, 8'h22);
    wait_cyc(40);
    cts_b = 1'b1;
    wait_cyc(250);
    check("cts_midbyte_frames", tx_starts.size(), 1);
    cpu_read(0, 8'h02, "status_cts_hold");
    cts_b = 1'b0;
    wait_cyc(250);
    check("cts_resume_frames", tx_starts.size(), 2);

    // Held by cts_b, then three frames back-to-back
    cts_b = 1'b1;
    wait_cyc(4);
    tx_starts.delete();
    tx_q.push_back(8'h81); tx_q.push_back(8'h42); tx_q.push_back(8'hC3);
    cpu_write(1, 8'h81); cpu_write(1, 8'h42); cpu_write(1, 8'hC3);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad = 1'b1;
    end
    check("cts_block_txd_low", bad, 0);
    cpu_read(0, 8'h02, "status_cts_queued");
    cts_b = 1'b0;
    wait_cyc(3 * FRAME + 60);
    check("b2b_frames", tx_starts.size(), 3);
    if (tx_starts.size() == 3) begin
      check("b2b_gap_1", tx_starts[1] - tx_starts[0], FRAME);
      check("b2b_gap_2", tx_starts[2] - tx_starts[1], FRAME);
    end

    // TX full: 17th write dropped
    cts_b = 1'b1;
    wait_cyc(4);
    tx_starts.delete();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) tx_q.push_back(8'(8'h60 + i));
      cpu_write(1, 8'(8'h60 + i));
    end
    cpu_read(0, 8'h00, "status_tx_full");
    cts_b = 1'b0;
    wait_cyc(16 * FRAME + 60);
    check("tx_full_frames", tx_starts.size(), 16);
    cpu_read(0, 8'h0A, "status_tx_drained");

    // RX with interrupt enable
    cpu_write(0, 8'h01);
    send_rx(8'hA3, 1'b1);
    wait_cyc(2);
    check("rx_irq_low", irq_b, 0);
    cpu_read(0, 8'h8B, "status_rx_irq");
    cpu_read(1, 8'hA3, "rx_data_A3");
    check("irq_hold_at_pop", irq_b, 0);
    wait_cyc(1);
    check("irq_release_after_pop", irq_b, 1);
    cpu_read(1, 8'h00, "rx_empty_read");
    cpu_write(0, 8'h00);

    // RTS threshold at 12 entries
    for (int i = 0; i < 11; i++) send_rx(8'(8'h10 + i), 1'b1);
    check("rts_below_thresh", rts_b, 0);
    send_rx(8'h1B, 1'b1);
    check("rts_at_thresh", rts_b, 1);
    cpu_read(0, 8'h0F, "status_rx_thresh");
    cpu_read(1, 8'h10, "rx_thresh_first");
    wait_cyc(2);
    check("rts_after_pop", rts_b, 0);
    for (int i = 1; i < 12; i++) cpu_read(1, 8'(8'h10 + i), "rx_thresh_data");

    // RX overflow: 17 bytes, 17th lost
    for (int i = 0; i < 17; i++) send_rx(8'(8'h20 + i), 1'b1);
    cpu_read(0, EN ? 8'h1F : 8'h0F, "status_overrun");
    cpu_read(0, 8'h0F, "status_overrun_cleared");
    for (int i = 0; i < 16; i++) cpu_read(1, 8'(8'h20 + i), "rx_overflow_data");
    cpu_read(1, 8'h00, "rx_overflow_17th_lost");

    // Bad stop bit
    send_rx(8'h5A, 1'b0);
    cpu_read(0, EN ? 8'h2A : 8'h0B, "status_framing");
    cpu_read(1, EN ? 8'h00 : 8'h5A, "rx_framing_data");

    // False start glitch
    @(posedge clk); #1;
    rxd = 1'b0;
    wait_cyc(3);
    rxd = 1'b1;
    wait_cyc(40);
    cpu_read(0, 8'h0A, "status_false_start");

    wait_cyc(20);
    check("rd_queue_drained", rd_q.size(), 0);
    check("tx_queue_drained", tx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
